// File: rtl/request_unit.sv
// request_unit: sequences instruction fetch, decode hold and data-memory
// requests for the multicycle MIPS core. PC advance and write-back are gated
// until each instruction's requests complete; a watchdog turns a hung memory
// handshake into a sticky error plus halt.
module request_unit #(
  parameter int TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        dhit,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        mem_halt,
  output logic [31:0] instr,
  output logic        iREN,
  output logic        dREN,
  output logic        dWEN,
  output logic        PC_EN,
  output logic        wb_en,
  output logic        halt,
  output logic        err,
  output logic [31:0] retired
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    MEM    = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t         state_q;
  logic [31:0]    instr_q;
  logic           dren_q;
  logic           dwen_q;
  logic           halt_q;
  logic           err_q;
  logic [31:0]    retired_q;
  logic [WDW-1:0] wd_q;
  logic           done_s;
  logic           wd_fire_s;

  // Completion strobe: a non-memory instruction retires in EXEC, a memory one on its dhit.
  always_comb begin
    done_s = 1'b0;
    case (state_q)
      EXEC:    done_s = ~mem_halt & ~(MemRead | MemWrite);
      MEM:     done_s = dhit;
      default: done_s = 1'b0;
    endcase
  end

  // Watchdog expiry: the waiting state has used its last allowed cycle.
  always_comb begin
    if (wd_q == WD_LAST) begin
      wd_fire_s = 1'b1;
    end else begin
      wd_fire_s = 1'b0;
    end
  end

  // Main sequencer: state, latched instruction, data requests, watchdog and counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= FETCH;
      instr_q   <= 32'd0;
      dren_q    <= 1'b0;
      dwen_q    <= 1'b0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
      retired_q <= 32'd0;
      wd_q      <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          if (ihit) begin
            instr_q <= imemload;
            state_q <= EXEC;
            wd_q    <= '0;
          end else if (wd_fire_s) begin
            err_q   <= 1'b1;
            halt_q  <= 1'b1;
            state_q <= HALTED;
            wd_q    <= '0;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        EXEC: begin
          wd_q <= '0;
          if (mem_halt) begin
            halt_q  <= 1'b1;
            state_q <= HALTED;
          end else if (MemRead | MemWrite) begin
            // A write request takes precedence when both are decoded.
            dwen_q  <= MemWrite;
            dren_q  <= MemRead & ~MemWrite;
            state_q <= MEM;
          end else begin
            retired_q <= retired_q + 32'd1;
            state_q   <= FETCH;
          end
        end
        MEM: begin
          if (dhit) begin
            retired_q <= retired_q + 32'd1;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
            state_q   <= FETCH;
            wd_q      <= '0;
          end else if (wd_fire_s) begin
            err_q   <= 1'b1;
            halt_q  <= 1'b1;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            state_q <= HALTED;
            wd_q    <= '0;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        HALTED: begin
          state_q <= HALTED;
          dren_q  <= 1'b0;
          dwen_q  <= 1'b0;
          wd_q    <= '0;
        end
        default: begin
          state_q <= FETCH;
          dren_q  <= 1'b0;
          dwen_q  <= 1'b0;
          wd_q    <= '0;
        end
      endcase
    end
  end

  assign iREN    = (state_q == FETCH);
  assign instr   = instr_q;
  assign dREN    = dren_q;
  assign dWEN    = dwen_q;
  assign PC_EN   = done_s;
  assign wb_en   = done_s;
  assign halt    = halt_q;
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit (TIMEOUT=8). Each retiring instruction
// pushes its expected instr/retired pair when its ihit is driven; the monitor
// pops and compares it whenever the DUT raises PC_EN.
module tb_request_unit;

  logic        CLK, RST, ihit, dhit, MemRead, MemWrite, mem_halt;
  logic [31:0] imemload, instr, retired;
  logic        iREN, dREN, dWEN, PC_EN, wb_en, halt, err;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] retired;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  request_unit #(.TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .dhit(dhit),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_halt(mem_halt),
    .instr(instr), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .PC_EN(PC_EN),
    .wb_en(wb_en), .halt(halt), .err(err), .retired(retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Scoreboard monitor: every completion pulse must match a pending expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && (PC_EN || wb_en)) begin
      n_tot++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: PC_EN=%b wb_en=%b with no pending instruction", PC_EN, wb_en);
      end else begin
        e = sb.pop_front();
        if (PC_EN !== 1'b1 || wb_en !== 1'b1 || instr !== e.instr || retired !== e.retired)
          $display("FAIL sb_complete: PC_EN=%b wb_en=%b instr=%h retired=%0d, want 1 1 %h %0d",
                   PC_EN, wb_en, instr, retired, e.instr, e.retired);
        else n_pass++;
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    ihit = 1'b0; dhit = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; mem_halt = 1'b0;
    imemload = 32'd0;
    RST = 1'b1;
    sb.delete();
    cyc();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc();
    #2;
    RST = 1'b1;
    #1;
    n_tot++;
    if ({iREN, dREN, dWEN, PC_EN, wb_en, halt, err} !== 7'b1000000 || instr !== 32'd0 || retired !== 32'd0)
      $display("FAIL reset_state: iREN,dREN,dWEN,PC_EN,wb_en,halt,err=%b instr=%h retired=%0d, want 1000000 0 0",
               {iREN, dREN, dWEN, PC_EN, wb_en, halt, err}, instr, retired);
    else n_pass++;
    cyc();
    RST = 1'b0;
  endtask

  task automatic test_alu();
    do_reset();
    ihit = 1'b1; imemload = 32'h0022_1820;
    sb.push_back('{32'h0022_1820, 32'd0});
    @(negedge CLK);
    n_tot++;
    if (iREN !== 1'b1 || PC_EN !== 1'b0) $display("FAIL alu_fetch: iREN=%b PC_EN=%b, want 1 0", iREN, PC_EN);
    else n_pass++;
    cyc();
    ihit = 1'b0; imemload = 32'hDEAD_BEEF;
    @(negedge CLK);
    n_tot++;
    if (instr !== 32'h0022_1820 || PC_EN !== 1'b1 || iREN !== 1'b0)
      $display("FAIL alu_exec: instr=%h PC_EN=%b iREN=%b, want 00221820 1 0", instr, PC_EN, iREN);
    else n_pass++;
    cyc();
    @(negedge CLK);
    n_tot++;
    if (PC_EN !== 1'b0 || iREN !== 1'b1 || retired !== 32'd1 || instr !== 32'h0022_1820)
      $display("FAIL alu_after: PC_EN=%b iREN=%b retired=%0d instr=%h, want 0 1 1 00221820", PC_EN, iREN, retired, instr);
    else n_pass++;
  endtask

  task automatic test_lw();
    int dren_cycles = 0;
    do_reset();
    ihit = 1'b1; imemload = 32'h8C22_0004;
    sb.push_back('{32'h8C22_0004, 32'd0});
    cyc();
    ihit = 1'b0; MemRead = 1'b1;
    @(negedge CLK);
    n_tot++;
    if (PC_EN !== 1'b0 || dREN !== 1'b0) $display("FAIL lw_exec: PC_EN=%b dREN=%b, want 0 0", PC_EN, dREN);
    else n_pass++;
    cyc();
    MemRead = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      dhit = (k == 3);
      @(negedge CLK);
      if (dREN === 1'b1) dren_cycles++;
      n_tot++;
      if (dREN !== 1'b1 || dWEN !== 1'b0 || iREN !== 1'b0 || PC_EN !== (k == 3) || instr !== 32'h8C22_0004)
        $display("FAIL lw_mem%0d: dREN=%b dWEN=%b iREN=%b PC_EN=%b instr=%h, want 1 0 0 %b 8c220004",
                 k, dREN, dWEN, iREN, PC_EN, instr, (k == 3));
      else n_pass++;
      cyc();
    end
    dhit = 1'b0;
    @(negedge CLK);
    n_tot++;
    if (dREN !== 1'b0 || iREN !== 1'b1 || retired !== 32'd1 || dren_cycles != 3)
      $display("FAIL lw_after: dREN=%b iREN=%b retired=%0d dren_cycles=%0d, want 0 1 1 3", dREN, iREN, retired, dren_cycles);
    else n_pass++;
  endtask

  task automatic test_rw_both();
    do_reset();
    ihit = 1'b1; imemload = 32'hAC22_0008;
    sb.push_back('{32'hAC22_0008, 32'd0});
    cyc();
    ihit = 1'b0; MemRead = 1'b1; MemWrite = 1'b1;
    cyc();
    MemRead = 1'b0; MemWrite = 1'b0; dhit = 1'b1;
    @(negedge CLK);
    n_tot++;
    if (dWEN !== 1'b1 || dREN !== 1'b0 || PC_EN !== 1'b1)
      $display("FAIL rw_mem: dWEN=%b dREN=%b PC_EN=%b, want 1 0 1", dWEN, dREN, PC_EN);
    else n_pass++;
    cyc();
    dhit = 1'b0;
    @(negedge CLK);
    n_tot++;
    if (dWEN !== 1'b0 || iREN !== 1'b1 || PC_EN !== 1'b0 || retired !== 32'd1)
      $display("FAIL rw_after: dWEN=%b iREN=%b PC_EN=%b retired=%0d, want 0 1 0 1", dWEN, iREN, PC_EN, retired);
    else n_pass++;
  endtask

  task automatic test_halt();
    do_reset();
    ihit = 1'b1; imemload = 32'hFFFF_FFFF;
    cyc();
    ihit = 1'b0; mem_halt = 1'b1;
    @(negedge CLK);
    n_tot++;
    if (PC_EN !== 1'b0 || halt !== 1'b0) $display("FAIL halt_exec: PC_EN=%b halt=%b, want 0 0", PC_EN, halt);
    else n_pass++;
    cyc();
    mem_halt = 1'b0;
    for (int k = 0; k < 20; k++) begin
      ihit = 1'($urandom); dhit = 1'($urandom); imemload = $urandom;
      MemRead = 1'($urandom); MemWrite = 1'($urandom);
      @(negedge CLK);
      n_tot++;
      if ({iREN, dREN, dWEN, PC_EN, halt, err} !== 6'b000010 || retired !== 32'd0 || instr !== 32'hFFFF_FFFF)
        $display("FAIL halt_hold%0d: iREN,dREN,dWEN,PC_EN,halt,err=%b retired=%0d instr=%h, want 000010 0 ffffffff",
                 k, {iREN, dREN, dWEN, PC_EN, halt, err}, retired, instr);
      else n_pass++;
      cyc();
    end
  endtask

  task automatic test_wd_fetch(input bit hit_last);
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      ihit = (hit_last && k == 8); imemload = 32'h0000_0020;
      if (ihit) sb.push_back('{32'h0000_0020, 32'd0});
      @(negedge CLK);
      n_tot++;
      if (iREN !== 1'b1 || err !== 1'b0)
        $display("FAIL wd_fetch_wait%0d: iREN=%b err=%b, want 1 0", k, iREN, err);
      else n_pass++;
      cyc();
    end
    ihit = 1'b0;
    @(negedge CLK);
    n_tot++;
    if (hit_last) begin
      if (err !== 1'b0 || halt !== 1'b0 || instr !== 32'h0000_0020 || PC_EN !== 1'b1)
        $display("FAIL wd_fetch_hit: err=%b halt=%b instr=%h PC_EN=%b, want 0 0 00000020 1", err, halt, instr, PC_EN);
      else n_pass++;
    end else begin
      if (err !== 1'b1 || halt !== 1'b1 || iREN !== 1'b0 || instr !== 32'd0)
        $display("FAIL wd_fetch_fire: err=%b halt=%b iREN=%b instr=%h, want 1 1 0 0", err, halt, iREN, instr);
      else n_pass++;
    end
    cyc();
  endtask

  task automatic test_wd_mem();
    do_reset();
    ihit = 1'b1; imemload = 32'h8C22_0004;
    cyc();
    ihit = 1'b0; MemRead = 1'b1;
    cyc();
    MemRead = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      n_tot++;
      if (dREN !== 1'b1 || err !== 1'b0) $display("FAIL wd_mem_wait%0d: dREN=%b err=%b, want 1 0", k, dREN, err);
      else n_pass++;
      cyc();
    end
    @(negedge CLK);
    n_tot++;
    if (err !== 1'b1 || halt !== 1'b1 || dREN !== 1'b0 || iREN !== 1'b0 || retired !== 32'd0)
      $display("FAIL wd_mem_fire: err=%b halt=%b dREN=%b iREN=%b retired=%0d, want 1 1 0 0 0", err, halt, dREN, iREN, retired);
    else n_pass++;
  endtask

  task automatic test_rst_mid_mem();
    do_reset();
    ihit = 1'b1; imemload = 32'h0022_1820;
    sb.push_back('{32'h0022_1820, 32'd0});
    cyc();
    ihit = 1'b0;
    cyc();
    ihit = 1'b1; imemload = 32'hAC22_0004;
    cyc();
    ihit = 1'b0; MemWrite = 1'b1;
    cyc();
    MemWrite = 1'b0;
    cyc();
    @(negedge CLK);
    n_tot++;
    if (dWEN !== 1'b1 || retired !== 32'd1) $display("FAIL rst_mem_pre: dWEN=%b retired=%0d, want 1 1", dWEN, retired);
    else n_pass++;
    #1;
    RST = 1'b1;
    #1;
    n_tot++;
    if (dWEN !== 1'b0 || iREN !== 1'b1 || retired !== 32'd0 || PC_EN !== 1'b0)
      $display("FAIL rst_mem_async: dWEN=%b iREN=%b retired=%0d PC_EN=%b, want 1->0 1 0 0", dWEN, iREN, retired, PC_EN);
    else n_pass++;
    cyc();
    RST = 1'b0;
    ihit = 1'b1; imemload = 32'h0043_2020;
    sb.push_back('{32'h0043_2020, 32'd0});
    cyc();
    ihit = 1'b0;
    cyc();
    @(negedge CLK);
    n_tot++;
    if (retired !== 32'd1 || instr !== 32'h0043_2020 || iREN !== 1'b1)
      $display("FAIL rst_mem_resume: retired=%0d instr=%h iREN=%b, want 1 00432020 1", retired, instr, iREN);
    else n_pass++;
  endtask

  initial begin
    RST = 1'b1;
    test_reset();
    test_alu();
    test_lw();
    test_rw_both();
    test_halt();
    test_wd_fetch(1'b0);
    test_wd_fetch(1'b1);
    test_wd_mem();
    test_rst_mid_mem();
    cyc();
    n_tot++;
    if (sb.size() != 0) $display("FAIL sb_drain: %0d expected completions never seen, want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
